// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller with 16x oversampling
//
// Deserialises the RXD line into bytes for the Rx FIFO controller.
// A programmable divisor sets the sample tick rate. RxDone is a
// level-held strobe, so a downstream stage can resynchronise it and
// edge-detect it.
//
// Optional build macro: UART_RX_PARITY_EN
//   defined   - ParityEn/ParityOdd are honoured and the PARITY state exists
//   undefined - frames are always 10 bits and ParityErr is tied to 0
//
// Ports:
//   DSP_CLK    in   block clock
//   RESET      in   asynchronous reset, active-high
//   RXD        in   serial receive line, asynchronous, idle high
//   RxEn       in   receiver enable; dropping it mid-frame aborts the frame
//   BaudDiv    in   sample tick every BaudDiv+1 clocks
//   ParityEn   in   parity bit expected
//   ParityOdd  in   1 = odd parity, 0 = even parity
//   RxBusy     out  frame reception in progress
//   RxDone     out  byte available, held high for 8 sample ticks
//   RxData     out  last received byte
//   FrameErr   out  stop bit of last byte sampled low
//   ParityErr  out  parity mismatch on last byte

`timescale 1ns/1ps

module uart_rx_ctrl #(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic             DSP_CLK,
  input  logic             RESET,
  input  logic             RXD,
  input  logic             RxEn,
  input  logic [DIV_W-1:0] BaudDiv,
  input  logic             ParityEn,
  input  logic             ParityOdd,
  output logic             RxBusy,
  output logic             RxDone,
  output logic [7:0]       RxData,
  output logic             FrameErr,
  output logic             ParityErr
);

  // Mid-bit and end-of-bit positions of the sample counter.
  localparam logic [3:0] SAMP_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] SAMP_LAST = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  // RXD synchroniser; rxs_prev_q keeps the previous synchronised value
  // for falling-edge detection.
  logic rx_meta_q;
  logic rxs_q;
  logic rxs_prev_q;

  state_t           state_q,  state_d;
  logic [DIV_W-1:0] div_q,    div_d;
  logic [3:0]       samp_q,   samp_d;
  logic [2:0]       bit_q,    bit_d;
  logic [7:0]       shift_q,  shift_d;
  logic [7:0]       data_q,   data_d;
  logic             ferr_q,   ferr_d;
  logic             done_q,   done_d;
  logic [DIV_W-1:0] ddiv_q,   ddiv_d;
  logic [2:0]       dtick_q,  dtick_d;
`ifdef UART_RX_PARITY_EN
  logic             par_q,    par_d;
  logic             perr_q,   perr_d;
`endif

  logic tick;
  logic fall;
  logic abort;

  always_ff @(posedge DSP_CLK or posedge RESET) begin
    if (RESET) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= RXD;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  always_ff @(posedge DSP_CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      samp_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
      ddiv_q  <= '0;
      dtick_q <= '0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
      ddiv_q  <= ddiv_d;
      dtick_q <= dtick_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    ferr_d  = ferr_q;
    done_d  = done_q;
    ddiv_d  = ddiv_q;
    dtick_d = dtick_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif

    fall  = rxs_prev_q & ~rxs_q;
    tick  = (state_q != S_IDLE) && (div_q == BaudDiv);
    abort = (state_q != S_IDLE) && !RxEn;

    // Divider is parked at 0 in IDLE so the first tick lands a fixed
    // distance after the detected start edge.
    if (state_q == S_IDLE || tick) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    // RxDone timing uses its own divider so a new frame starting while
    // RxDone is high cannot disturb its length.
    if (done_q) begin
      if (ddiv_q == BaudDiv) begin
        ddiv_d  = '0;
        dtick_d = dtick_q + 3'd1;
        if (dtick_q == 3'd7) begin
          done_d = 1'b0;
        end
      end else begin
        ddiv_d = ddiv_q + DIV_W'(1);
      end
    end

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (RxEn && fall) begin
            state_d = S_START;
            samp_d  = '0;
          end
        end

        S_START: begin
          if (tick) begin
            if (samp_q == SAMP_MID) begin
              samp_d = '0;
              bit_d  = '0;
              // A line that is high again at mid-bit was a glitch.
              state_d = rxs_q ? S_IDLE : S_DATA;
            end else begin
              samp_d = samp_q + 4'd1;
            end
          end
        end

        S_DATA: begin
          if (tick) begin
            if (samp_q == SAMP_LAST) begin
              samp_d  = '0;
              shift_d = {rxs_q, shift_q[7:1]};
              if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state_d = ParityEn ? S_PARITY : S_STOP;
`else
                state_d = S_STOP;
`endif
              end else begin
                bit_d = bit_q + 3'd1;
              end
            end else begin
              samp_d = samp_q + 4'd1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            if (samp_q == SAMP_LAST) begin
              samp_d  = '0;
              par_d   = rxs_q;
              state_d = S_STOP;
            end else begin
              samp_d = samp_q + 4'd1;
            end
          end
        end
`endif

        S_STOP: begin
          if (tick) begin
            if (samp_q == SAMP_LAST) begin
              samp_d  = '0;
              data_d  = shift_q;
              ferr_d  = ~rxs_q;
`ifdef UART_RX_PARITY_EN
              perr_d  = ParityEn ? ((^{shift_q, par_q}) != ParityOdd) : 1'b0;
`endif
              done_d  = 1'b1;
              ddiv_d  = '0;
              dtick_d = '0;
              // A low stop bit may be the start of a break; wait for the
              // line to return high before hunting for a new start edge.
              state_d = rxs_q ? S_IDLE : S_BREAK;
            end else begin
              samp_d = samp_q + 4'd1;
            end
          end
        end

        S_BREAK: begin
          if (rxs_q) begin
            state_d = S_IDLE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  assign RxBusy   = (state_q == S_START) || (state_q == S_DATA) ||
`ifdef UART_RX_PARITY_EN
                    (state_q == S_PARITY) ||
`endif
                    (state_q == S_STOP);
  assign RxDone   = done_q;
  assign RxData   = data_q;
  assign FrameErr = ferr_q;

`ifdef UART_RX_PARITY_EN
  assign ParityErr = perr_q;
`else
  assign ParityErr = 1'b0;
  logic unused_parity;
  assign unused_parity = ParityEn ^ ParityOdd;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl

`timescale 1ns/1ps

module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxd;
  logic        rx_en;
  logic [15:0] baud;
  logic        par_en;
  logic        par_odd;
  logic        busy;
  logic        done;
  logic [7:0]  data;
  logic        ferr;
  logic        perr;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } cap_t;

  typedef struct {
    int         div;
    logic [7:0] d;
    logic       stop;
    logic [7:0] exp_d;
    logic       exp_fe;
  } vec_t;

  cap_t caps[$];
  int   lens[$];
  int   busy_lens[$];
  int   stab_err = 0;

  uart_rx_ctrl #(.OVERSAMPLE(16), .DIV_W(16)) dut (
    .DSP_CLK   (clk),
    .RESET     (rst),
    .RXD       (rxd),
    .RxEn      (rx_en),
    .BaudDiv   (baud),
    .ParityEn  (par_en),
    .ParityOdd (par_odd),
    .RxBusy    (busy),
    .RxDone    (done),
    .RxData    (data),
    .FrameErr  (ferr),
    .ParityErr (perr)
  );

  always #5 clk = ~clk;

  // Output monitor: captures data at each RxDone rise, measures RxDone
  // and RxBusy high times, and flags RxData changes while RxDone is high.
  logic done_prev = 1'b0;
  logic busy_prev = 1'b0;
  int   done_len  = 0;
  int   busy_len  = 0;
  cap_t cur;

  always @(negedge clk) begin
    if (done && !done_prev) begin
      cur = '{d: data, fe: ferr, pe: perr};
      caps.push_back(cur);
      done_len = 1;
    end else if (done) begin
      done_len++;
      if (data != cur.d || ferr != cur.fe || perr != cur.pe) stab_err++;
    end
    if (!done && done_prev) lens.push_back(done_len);
    if (busy) busy_len = busy_prev ? busy_len + 1 : 1;
    if (!busy && busy_prev) busy_lens.push_back(busy_len);
    done_prev = done;
    busy_prev = busy;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    caps.delete();
    lens.delete();
    busy_lens.delete();
  endtask

  // Called on a negedge; leaves RXD at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input int div, input logic stop,
                            input logic with_par, input logic par);
    int bp;
    bp = 16 * (div + 1);
    rxd = 1'b0;
    repeat (bp) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (bp) @(negedge clk);
    end
    if (with_par) begin
      rxd = par;
      repeat (bp) @(negedge clk);
    end
    rxd = stop;
    repeat (bp) @(negedge clk);
  endtask

  task automatic check_cap(input string name, input logic [7:0] d,
                           input logic fe, input logic pe);
    cap_t c;
    check({name, "_seen"}, (caps.size() > 0) ? 1 : 0, 1);
    if (caps.size() > 0) begin
      c = caps.pop_front();
      check({name, "_data"}, c.d, d);
      check({name, "_ferr"}, c.fe, fe);
      check({name, "_perr"}, c.pe, pe);
    end
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{div: 3, d: 8'hA5, stop: 1'b1, exp_d: 8'hA5, exp_fe: 1'b0};
    vecs[1] = '{div: 0, d: 8'h00, stop: 1'b1, exp_d: 8'h00, exp_fe: 1'b0};
    vecs[2] = '{div: 1, d: 8'hFF, stop: 1'b1, exp_d: 8'hFF, exp_fe: 1'b0};
    vecs[3] = '{div: 2, d: 8'h3C, stop: 1'b0, exp_d: 8'h3C, exp_fe: 1'b1};
    vecs[4] = '{div: 0, d: 8'h81, stop: 1'b1, exp_d: 8'h81, exp_fe: 1'b0};

    rst = 1'b0; rxd = 1'b1; rx_en = 1'b1; baud = 16'd3; par_en = 1'b0; par_odd = 1'b0;

    // Asynchronous reset asserted between clock edges.
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_data", data, 8'h00);
    check("reset_ferr", ferr, 0);
    check("reset_perr", perr, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    clear_mon();

    // Table-driven frames.
    for (int i = 0; i < 5; i++) begin
      baud = 16'(vecs[i].div);
      repeat (4) @(negedge clk);
      send_frame(vecs[i].d, vecs[i].div, vecs[i].stop, 1'b0, 1'b0);
      rxd = 1'b1;
      repeat (8 * (vecs[i].div + 1) + 40) @(negedge clk);
      check($sformatf("v%0d_count", i), caps.size(), 1);
      check_cap($sformatf("v%0d", i), vecs[i].exp_d, vecs[i].exp_fe, 1'b0);
      check($sformatf("v%0d_done_len", i), (lens.size() > 0) ? lens[0] : -1,
            8 * (vecs[i].div + 1));
      if (i == 0) begin
        check("v0_busy_about_600",
              (busy_lens.size() > 0 && busy_lens[0] >= 590 && busy_lens[0] <= 620) ? 1 : 0, 1);
      end
      clear_mon();
    end

    // False start: 20 clk low pulse is high again by mid-start.
    baud = 16'd3;
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    rxd = 1'b1;
    repeat (200) @(negedge clk);
    check("false_no_done", caps.size(), 0);
    check("false_data", data, 8'h81);
    check("false_busy", busy, 0);
    clear_mon();

    // Framing error followed by a long break, then a good frame.
    send_frame(8'h3C, 3, 1'b0, 1'b0, 1'b0);
    repeat (2000) @(negedge clk);
    check("break_one_frame", caps.size(), 1);
    check("break_busy", busy, 0);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    send_frame(8'h55, 3, 1'b1, 1'b0, 1'b0);
    rxd = 1'b1;
    repeat (80) @(negedge clk);
    check("break_count", caps.size(), 2);
    check_cap("break_f1", 8'h3C, 1'b1, 1'b0);
    check_cap("break_f2", 8'h55, 1'b0, 1'b0);
    clear_mon();

`ifdef UART_RX_PARITY_EN
    // Even parity over 8'h07: parity bit 1 is correct, 0 is wrong.
    par_en = 1'b1; par_odd = 1'b0;
    send_frame(8'h07, 3, 1'b1, 1'b1, 1'b1);
    rxd = 1'b1;
    repeat (80) @(negedge clk);
    check_cap("par_ok", 8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 3, 1'b1, 1'b1, 1'b0);
    rxd = 1'b1;
    repeat (80) @(negedge clk);
    check_cap("par_bad", 8'h07, 1'b0, 1'b1);
`else
    // Parity ports are ignored: a plain 10-bit frame is received cleanly.
    par_en = 1'b1; par_odd = 1'b1;
    send_frame(8'h07, 3, 1'b1, 1'b0, 1'b0);
    rxd = 1'b1;
    repeat (80) @(negedge clk);
    check_cap("par_ignored", 8'h07, 1'b0, 1'b0);
`endif
    par_en = 1'b0; par_odd = 1'b0;
    clear_mon();

    // Back-to-back frames with no idle gap at the fastest rate.
    baud = 16'd0;
    repeat (4) @(negedge clk);
    send_frame(8'h01, 0, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFE, 0, 1'b1, 1'b0, 1'b0);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("b2b_count", caps.size(), 2);
    check_cap("b2b_f1", 8'h01, 1'b0, 1'b0);
    check_cap("b2b_f2", 8'hFE, 1'b0, 1'b0);
    check("b2b_len1", (lens.size() > 0) ? lens[0] : -1, 8);
    check("b2b_len2", (lens.size() > 1) ? lens[1] : -1, 8);
    clear_mon();

    // Abort by dropping RxEn in the middle of data bit 3.
    begin
      logic [7:0] ad;
      ad = 8'h5A;
      rxd = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        rxd = ad[i];
        repeat (16) @(negedge clk);
      end
      rxd = ad[3];
      repeat (8) @(negedge clk);
      check("abort_busy_before", busy, 1);
      rx_en = 1'b0;
      @(negedge clk);
      check("abort_busy_after", busy, 0);
      repeat (7) @(negedge clk);
      for (int i = 4; i < 8; i++) begin
        rxd = ad[i];
        repeat (16) @(negedge clk);
      end
      rxd = 1'b1;
      repeat (60) @(negedge clk);
      check("abort_no_done", caps.size(), 0);
      check("abort_data", data, 8'hFE);
      rx_en = 1'b1;
    end

    check("done_hold_stable", stab_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
UART receive controller. It deserialises the RXD line into bytes and sits directly upstream of the Rx FIFO controller, driving that block's RxBusy, RxDone and RxData inputs. Sampling uses 16x oversampling from a programmable baud divisor. The output handshake is a level-held done strobe, so a downstream stage can resynchronise it and edge-detect it.

Parameters:
OVERSAMPLE, 16, sample ticks per bit; fixed at 16, present for documentation only
DIV_W, 16, width of the baud divisor input

Ports:
DSP_CLK  input  1  block clock
RESET  input  1  asynchronous reset, active-high
RXD  input  1  serial receive line, asynchronous, idle high
RxEn  input  1  receiver enable
BaudDiv  input  DIV_W  sample tick every BaudDiv+1 DSP_CLK cycles
ParityEn  input  1  parity bit expected (see Optional Feature)
ParityOdd  input  1  1 = odd parity, 0 = even parity
RxBusy  output  1  frame reception in progress
RxDone  output  1  byte available; held high for 8 sample ticks
RxData  output  8  last received byte, LSB first on the line
FrameErr  output  1  stop bit of last byte sampled low
ParityErr  output  1  parity mismatch on last byte

Behaviour:
- Interface: one clock, DSP_CLK. RESET is asynchronous and active-high.
- Reset values:
  - all outputs 0; RxData = 8'h00
  - state IDLE; all counters 0
  - RXD synchroniser flops reset to 1
- RXD passes through a 2-flop synchroniser. All decisions use the synchronised value rxs.
- Tick generator:
  - 16-bit counter counts 0..BaudDiv; tick fires on the cycle the count equals BaudDiv, then the count clears.
  - BaudDiv = 0 gives a tick every cycle.
  - The counter is held at 0 while in IDLE, so phase aligns to start-bit detection.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE:
  - if RxEn=1 and rxs falls (1 to 0), go to START and clear the sample count.
  - RxBusy=0.
- START:
  - on the 8th tick (sample count 7, mid-bit), if rxs=0 go to DATA with bit index 0; otherwise it is a false start: go back to IDLE, no outputs change.
  - RxBusy=1 from the cycle START is entered.
- DATA:
  - every 16 ticks after the mid-start sample, shift rxs into a shift register, LSB first.
  - after bit 7, go to PARITY if parity is enabled, otherwise STOP.
- PARITY: sample at mid-bit and compute the parity check over data plus parity bit.
- STOP, on the mid-bit sample:
  - RxData <= shift register; FrameErr <= ~rxs; ParityErr <= mismatch (0 if parity off).
  - RxDone rises 1 cycle after the sample; RxBusy falls the same cycle.
  - if rxs=0, go to BREAK; otherwise go to IDLE.
- BREAK: wait until rxs=1, then go to IDLE. No new frame is detected while in BREAK.
- RxDone:
  - high for exactly 8 ticks, then low.
  - RxData, FrameErr and ParityErr are stable while RxDone=1 and until the next RxDone rise.
  - a new start bit detected while RxDone is still high does not shorten the RxDone high time.
- RxEn:
  - deasserting RxEn mid-frame aborts to IDLE on the next cycle: RxBusy=0, no RxDone, RxData unchanged.
  - changes to BaudDiv mid-frame are undefined; software changes BaudDiv only while RxBusy=0.
- Back-to-back frames: a start edge on the cycle IDLE is re-entered is detected, giving zero-gap reception.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - ParityEn and ParityOdd are honoured; the PARITY state exists.
  - ParityErr is set when the XOR of the 8 data bits and the parity bit is not equal to ParityOdd.
- Undefined:
  - PARITY state and parity logic are removed.
  - ParityEn and ParityOdd ports remain but are ignored.
  - ParityErr is tied to 0; frames are always 10 bits.

Test Plan:
- Reset: with RXD=1, assert RESET mid-cycle -> immediately RxBusy=0, RxDone=0, RxData=00, FrameErr=0, ParityErr=0.
- Basic receive: BaudDiv=3 (64 clk/bit), send 8'hA5 8N1 -> RxBusy high about 600 clk; RxData=A5 when RxDone rises; RxDone high 32 clk; FrameErr=0.
- False start: BaudDiv=3, drive RXD low for 20 clk then high -> returns to IDLE; no RxDone; RxData unchanged.
- Framing and break: send 8'h3C with stop=0, hold RXD low 2000 clk, then send 8'h55 -> first RxDone gives RxData=3C, FrameErr=1; no frame during the low period; second RxDone gives RxData=55, FrameErr=0.
- Parity (macro on): ParityEn=1, ParityOdd=0, send 8'h07 with parity bit 1 -> ParityErr=0; repeat with parity bit 0 -> ParityErr=1, RxData=07.
- Back-to-back and abort: BaudDiv=0, send 8'h01 then 8'hFE with no idle gap -> two RxDone pulses with correct data; next frame: drop RxEn during bit 3 -> RxBusy=0 next cycle, no RxDone, RxData=FE.
